dct_transpose_buf: RTL and testbench

Ping-pong transpose buffer between two 1-D DCT passes of the 8x8 2-D DCT. Accepts one block of N×N coefficients from the row-pass `dct_1d` in row-major order and replays it to the column-pass `dct_1d` in column-major order, one sample per cycle. Two banks let the next block be written while the previous one is read out.

---
 rtl/dct_transpose_buf_pkg.sv | 14 +
 rtl/dct_transpose_buf_if.sv | 40 ++++
 rtl/dct_transpose_buf_bank.sv | 23 ++
 rtl/dct_transpose_buf.sv | 173 +++++++++++++++++
 tb/tb_dct_transpose_buf.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_transpose_buf_pkg.sv
// Shared constants, index type and read-FSM encoding for the DCT transpose buffer.
package dct_pkg;

  localparam int DCT_N      = 8;
  localparam int DCT_COEF_W = 16;

  typedef logic [$clog2(DCT_N*DCT_N)-1:0] dct_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/dct_transpose_buf_if.sv
// Stream bundle between the row-pass DCT, the transpose buffer and the column-pass DCT.
// Optional i_sof framing input exists only when DCT_TRANSPOSE_SOF_EN is defined.
interface dct_transpose_buf_if
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_COEF_W
);

  logic                  i_valid;
`ifdef DCT_TRANSPOSE_SOF_EN
  logic                  i_sof;
`endif
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;

  modport master (
    output i_valid,
`ifdef DCT_TRANSPOSE_SOF_EN
    output i_sof,
`endif
    output i_data,
    input  o_valid,
    input  o_data,
    input  o_last
  );

  modport slave (
    input  i_valid,
`ifdef DCT_TRANSPOSE_SOF_EN
    input  i_sof,
`endif
    input  i_data,
    output o_valid,
    output o_data,
    output o_last
  );

endinterface

// File: rtl/dct_transpose_buf_bank.sv
// One transpose bank: simple dual-port RAM with a single write port and a registered read port.
module dct_tbuf_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer: row-major block in, column-major block out, two banks.
// Define DCT_TRANSPOSE_SOF_EN to add i_sof block re-alignment on the write side.
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_COEF_W,
  parameter int N          = DCT_N
) (
  input  logic              i_clk,
  input  logic              i_rst,
  dct_transpose_buf_if.slave bus
);

  localparam int LN = $clog2(N);
  localparam int IW = 2 * LN;
  localparam logic [IW-1:0] LAST_IDX = IW'(N*N - 1);

  logic [IW-1:0]         wi, wi_nxt;
  logic [IW-1:0]         wr_addr;
  logic                  wr_bank, wr_bank_nxt;
  logic                  wr_done;
  logic                  sof;
  logic                  wr_en0, wr_en1;

  logic [1:0]            full, full_nxt, full_eff;

  rd_state_t             state, state_nxt;
  logic [IW-1:0]         ri, ri_nxt;
  logic                  rd_bank, rd_bank_nxt;
  logic                  rd_release;
  logic [IW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data0, rd_data1, rd_data;

  logic                  out_valid, out_last;
  logic [DATA_WIDTH-1:0] out_data;

`ifdef DCT_TRANSPOSE_SOF_EN
  assign sof = bus.i_valid & bus.i_sof;
`else
  assign sof = 1'b0;
`endif

  always_comb begin
    wi_nxt      = wi;
    wr_bank_nxt = wr_bank;
    wr_done     = 1'b0;
    if (bus.i_valid) begin
      if (sof) begin
        wi_nxt = IW'(1);
      end else if (wi == LAST_IDX) begin
        wr_done     = 1'b1;
        wi_nxt      = '0;
        wr_bank_nxt = ~wr_bank;
      end else begin
        wi_nxt = wi + 1'b1;
      end
    end
  end

  assign wr_addr = sof ? '0 : wi;
  assign wr_en0  = bus.i_valid & ~wr_bank;
  assign wr_en1  = bus.i_valid &  wr_bank;

  // A bank finishing its last write this cycle already counts as full, so the
  // reader can start (or chain) on the same edge and meet the t+2 latency.
  assign full_eff[0] = full[0] | (wr_done & ~wr_bank);
  assign full_eff[1] = full[1] | (wr_done &  wr_bank);

  always_comb begin
    full_nxt = full;
    if (wr_done)    full_nxt[wr_bank] = 1'b1;
    if (rd_release) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wi      <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      wi      <= wi_nxt;
      wr_bank <= wr_bank_nxt;
      full    <= full_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      ri      <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      ri      <= ri_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ri_nxt      = ri;
    rd_bank_nxt = rd_bank;
    rd_release  = 1'b0;
    case (state)
      IDLE: begin
        if (full_eff[rd_bank]) begin
          state_nxt = READ;
          ri_nxt    = '0;
        end
      end
      READ: begin
        if (ri == LAST_IDX) begin
          rd_release  = 1'b1;
          rd_bank_nxt = ~rd_bank;
          ri_nxt      = '0;
          if (!full_eff[~rd_bank]) state_nxt = IDLE;
        end else begin
          ri_nxt = ri + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address is issued from the next-state index so the registered RAM output
  // lines up with the current ri: ri = {col, row}, address = {row, col}.
  assign rd_addr = {ri_nxt[LN-1:0], ri_nxt[IW-1:LN]};

  dct_tbuf_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (N*N),
    .AW         (IW)
  ) u_bank0 (
    .clk     (i_clk),
    .wr_en   (wr_en0),
    .wr_addr (wr_addr),
    .wr_data (bus.i_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  dct_tbuf_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (N*N),
    .AW         (IW)
  ) u_bank1 (
    .clk     (i_clk),
    .wr_en   (wr_en1),
    .wr_addr (wr_addr),
    .wr_data (bus.i_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  assign rd_data = rd_bank ? rd_data1 : rd_data0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (state == READ);
      out_last  <= (state == READ) && (ri == LAST_IDX);
      if (state == READ) out_data <= rd_data;
    end
  end

  assign bus.o_valid = out_valid;
  assign bus.o_last  = out_last;
  assign bus.o_data  = out_data;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf: transpose order, latency, back-to-back chaining, resets.
`timescale 1ns/1ps
module tb_dct_transpose_buf;
  import dct_pkg::*;

  localparam int DW = DCT_COEF_W;
  localparam int N  = DCT_N;
  localparam int NN = DCT_N * DCT_N;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct_transpose_buf_if #(.DATA_WIDTH(DW)) bus ();

  dct_transpose_buf #(.DATA_WIDTH(DW), .N(N)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            c;
    logic [DW-1:0] d;
    logic          l;
  } out_t;

  out_t          oq [$];
  out_t          mon;
  int            stray_last = 0;
  int            collide    = 0;
  logic [DW-1:0] blk [4][NN];
  int            t_last [4];

  always @(negedge clk) begin
    if (bus.o_valid === 1'b1) begin
      mon.c = cyc;
      mon.d = bus.o_data;
      mon.l = bus.o_last;
      oq.push_back(mon);
    end else if (bus.o_last !== 1'b0) begin
      stray_last++;
    end
    if (rst_n && bus.i_valid && dut.state == READ && dut.wr_bank == dut.rd_bank)
      collide++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int b, input int gap, input bit sof_first, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = blk[b][k];
`ifdef DCT_TRANSPOSE_SOF_EN
      bus.i_sof   = sof_first && (k == 0);
`endif
      t_last[b] = cyc;
      tick();
      bus.i_valid = 1'b0;
`ifdef DCT_TRANSPOSE_SOF_EN
      bus.i_sof   = 1'b0;
`endif
      repeat (gap) tick();
    end
  endtask

  task automatic check_block(input int b, input string name);
    int   budget;
    int   a;
    out_t o;
    budget = 0;
    while (oq.size() < NN && budget < 400) begin
      tick();
      budget++;
    end
    total++;
    if (oq.size() < NN) begin
      bad++;
      $display("FAIL %s timeout: got %0d outputs, need %0d", name, oq.size(), NN);
      oq.delete();
      return;
    end
    for (int k = 0; k < NN; k++) begin
      o = oq.pop_front();
      a = (k % N) * N + (k / N);
      total++;
      if (o.d !== blk[b][a]) begin
        bad++;
        $display("FAIL %s data[%0d]: got %h, want %h", name, k, o.d, blk[b][a]);
      end
      total++;
      if (o.c !== t_last[b] + 2 + k) begin
        bad++;
        $display("FAIL %s cycle[%0d]: got %0d, want %0d", name, k, o.c, t_last[b] + 2 + k);
      end
      total++;
      if (o.l !== (k == NN - 1)) begin
        bad++;
        $display("FAIL %s last[%0d]: got %b, want %b", name, k, o.l, (k == NN - 1));
      end
    end
  endtask

  task automatic check_quiet(input string name, input int ncyc);
    repeat (ncyc) tick();
    total++;
    if (oq.size() != 0) begin
      bad++;
      $display("FAIL %s extra outputs: got %0d, want 0", name, oq.size());
    end
    oq.delete();
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
`ifdef DCT_TRANSPOSE_SOF_EN
    bus.i_sof   = 1'b0;
`endif
    #2 rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset o_valid: got %b, want 0", bus.o_valid); end
    total++;
    if (bus.o_last !== 1'b0) begin bad++; $display("FAIL reset o_last: got %b, want 0", bus.o_last); end
    total++;
    if (bus.o_data !== '0) begin bad++; $display("FAIL reset o_data: got %h, want 0", bus.o_data); end
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL post_reset o_valid: got %b, want 0", bus.o_valid); end
    oq.delete();
  endtask

  task automatic test_single_block();
    for (int k = 0; k < NN; k++) blk[0][k] = DW'(k);
    send_block(0, 0, 1'b0, NN);
    check_block(0, "single");
    repeat (3) tick();
    total++;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL hold o_valid: got %b, want 0", bus.o_valid); end
    total++;
    if (bus.o_data !== DW'(63)) begin bad++; $display("FAIL hold o_data: got %h, want 003f", bus.o_data); end
    total++;
    if (bus.o_last !== 1'b0) begin bad++; $display("FAIL hold o_last: got %b, want 0", bus.o_last); end
    check_quiet("single_tail", 5);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < NN; k++) blk[b][k] = DW'(b * 64 + k);
    for (int b = 0; b < 4; b++) send_block(b, 0, 1'b0, NN);
    check_block(0, "b2b_blk0");
    check_block(1, "b2b_blk1");
    check_block(2, "b2b_blk2");
    check_block(3, "b2b_blk3");
    check_quiet("b2b_tail", 5);
  endtask

  task automatic test_sparse_valid();
    for (int k = 0; k < NN; k++) blk[0][k] = DW'(16'h0A00 + k);
    send_block(0, 2, 1'b0, NN);
    check_block(0, "sparse");
    check_quiet("sparse_tail", 5);
  endtask

  task automatic test_reset_mid_block();
    for (int k = 0; k < NN; k++) blk[0][k] = DW'(1000 + k);
    for (int k = 0; k < NN; k++) blk[1][k] = DW'(100 + k);
    send_block(0, 0, 1'b0, 40);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    oq.delete();
    send_block(1, 0, 1'b0, NN);
    check_block(1, "rst_write");
    check_quiet("rst_write_tail", 5);

    for (int k = 0; k < NN; k++) blk[2][k] = DW'(500 + k);
    for (int k = 0; k < NN; k++) blk[3][k] = DW'(700 + k);
    send_block(2, 0, 1'b0, NN);
    repeat (10) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    oq.delete();
    send_block(3, 0, 1'b0, NN);
    check_block(3, "rst_read");
    check_quiet("rst_read_tail", 5);
  endtask

`ifdef DCT_TRANSPOSE_SOF_EN
  task automatic test_sof();
    for (int k = 0; k < NN; k++) blk[0][k] = DW'(900 + k);
    for (int k = 0; k < NN; k++) blk[1][k] = DW'(200 + k);
    send_block(0, 0, 1'b0, 20);
    send_block(1, 0, 1'b1, NN);
    check_block(1, "sof");
    check_quiet("sof_tail", 70);
  endtask
`endif

  task automatic test_extremes();
    for (int k = 0; k < NN; k++) blk[0][k] = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
    send_block(0, 0, 1'b0, NN);
    check_block(0, "extremes");
    check_quiet("extremes_tail", 5);
  endtask

  task automatic test_no_collision();
    total++;
    if (collide !== 0) begin bad++; $display("FAIL bank_collision: got %0d writes into read bank, want 0", collide); end
    total++;
    if (stray_last !== 0) begin bad++; $display("FAIL stray_last: got %0d o_last without o_valid, want 0", stray_last); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_sparse_valid();
    test_reset_mid_block();
`ifdef DCT_TRANSPOSE_SOF_EN
    test_sof();
`endif
    test_extremes();
    test_no_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
